pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Pipeline stall/flush scheduler for the 5-stage CPU. It sits beside the ID-stage control unit. It turns hazard conditions into enable and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers:
- load-use hazards, which forwarding cannot cover
- ID-stage redirects (branch/jump)
- multi-cycle data-memory waits, with a timeout

It also keeps saturating stall and flush counters for performance debug.

Parameters:
DELAY_SLOT, 1, 1 = architectural branch delay slot (no IF/ID flush on redirect); 0 = flush IF/ID on redirect
MEM_TIMEOUT, 255, max consecutive memory-wait freeze cycles before forced release (1..255)
CNT_W, 16, width of performance counters

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
rs  in  5  ID-stage rs field
rt  in  5  ID-stage rt field
use_rs  in  1  ID instruction reads rs
use_rt  in  1  ID instruction reads rt
ern  in  5  EX-stage destination register
em2reg  in  1  EX-stage instruction is a load
ewreg  in  1  EX-stage instruction writes a register
redirect  in  1  ID-stage PC redirect taken (pcsource != 0)
mmem_req  in  1  MEM-stage instruction accesses data memory (lw or sw)
mem_ready  in  1  data memory completes the access this cycle
wpcir  out  1  PC and IF/ID write enable
if_flush  out  1  IF/ID loads NOP
id_bubble  out  1  ID/EX loads zeroed controls
de_en  out  1  ID/EX write enable
em_en  out  1  EX/MEM write enable
mw_bubble  out  1  MEM/WB loads zeroed controls
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with wpcir=0, saturating
flush_cnt  out  CNT_W  IF/ID flushes issued, saturating

Behaviour:
- Reset: in the cycle after reset is sampled, state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- Reset applies mid-operation too, including inside MEM_WAIT: it overrides everything and no counter increments in that cycle.
- Defaults (no hazard): wpcir=1, de_en=1, em_en=1, if_flush=0, id_bubble=0, mw_bubble=0.
- All enable/bubble outputs are combinational from state, wait_cnt and the current inputs. Zero added latency.
- load_use = ewreg & em2reg & (ern!=0) & ((use_rs & rs==ern) | (use_rt & rt==ern)).
- mem_stall = mmem_req & ~mem_ready & ~(state==MEM_WAIT & wait_cnt==MEM_TIMEOUT).
- Priority, highest first: mem_stall > load_use > redirect.
- mem_stall:
  - Outputs: wpcir=0, de_en=0, em_en=0, mw_bubble=1, id_bubble=0, if_flush=0.
  - Next state=MEM_WAIT; wait_cnt <= wait_cnt+1.
- load_use (no mem_stall):
  - Outputs: wpcir=0, id_bubble=1, de_en=1, em_en=1, mw_bubble=0.
  - redirect is ignored, because the ID operands are invalid.
  - The stall lasts one cycle, since the load advances.
- redirect (no stall):
  - If DELAY_SLOT=0: if_flush=1 and flush_cnt increments.
  - If DELAY_SLOT=1: no effect.
- FSM RUN -> MEM_WAIT on mem_stall.
- FSM MEM_WAIT -> RUN when mem_ready=1, on forced release, or when mmem_req drops. wait_cnt <= 0 on every return to RUN.
- Forced release:
  - Occurs when state==MEM_WAIT and wait_cnt==MEM_TIMEOUT, i.e. after MEM_TIMEOUT freeze cycles.
  - In the release cycle, outputs follow the non-mem rules (the access is dropped).
  - mem_err <= 1 and stays set until reset.
- mem_ready=1 in the same cycle as mmem_req: no stall.
- stall_cnt increments by 1 each cycle wpcir=0. flush_cnt increments by 1 each cycle if_flush=1. Both hold at all-ones.

Decomposition:
- Shared package cpu_pipe_pkg: FSM state type (RUN=1'b0, MEM_WAIT=1'b1) and NOP/bubble control constants, reused by the pipeline registers.
- One natural sub-module: sat_counter (parameter W; ports clock, reset, inc, count). Instantiated for stall_cnt and flush_cnt.

Test Plan:
- Reset held 2 cycles then released, all inputs 0 -> wpcir=1, de_en=em_en=1, if_flush=id_bubble=mw_bubble=0, mem_err=0, stall_cnt=flush_cnt=0.
- Load-use at ern=5, em2reg=1, ewreg=1:
  - rs=5, use_rs=1 for 1 cycle -> wpcir=0, id_bubble=1 that cycle; stall_cnt=1.
  - Repeat with ern=0 -> no stall.
  - Repeat with use_rs=0 -> no stall.
- DELAY_SLOT=0, redirect=1 alone -> if_flush=1, flush_cnt=1. Redirect=1 together with load_use -> if_flush=0, id_bubble=1, flush_cnt unchanged.
- mmem_req=1 with mem_ready=0 for 3 cycles, then 1 -> 3 freeze cycles (wpcir=de_en=em_en=0, mw_bubble=1), release on cycle 4; stall_cnt=3, mem_err=0.
- MEM_TIMEOUT=4, mmem_req=1, mem_ready stuck 0 -> 4 freeze cycles, release on cycle 5, mem_err=1 from cycle 6 and stays 1 until reset.
- Reset asserted on the 2nd cycle of MEM_WAIT -> next cycle state=RUN, counters 0, mem_err 0, and the freeze follows the current mmem_req/mem_ready.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline control types: hazard FSM state, stage-control bundle, NOP constants.
// Pure declarations, no logic and no latency.
// No flow control of its own; consumers apply the enables and bubbles.
package cpu_pipe_pkg;

    // Hazard scheduler state: RUN is normal flow, MEM_WAIT is a data-memory freeze.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // Enable/bubble bundle driven to the PC and the four pipeline registers.
    typedef struct packed {
        logic wpcir;      // PC and IF/ID write enable
        logic if_flush;   // IF/ID loads NOP
        logic id_bubble;  // ID/EX loads zeroed controls
        logic de_en;      // ID/EX write enable
        logic em_en;      // EX/MEM write enable
        logic mw_bubble;  // MEM/WB loads zeroed controls
    } hz_ctrl_t;

    // Free-flowing pipeline: everything advances, nothing is squashed.
    localparam hz_ctrl_t CTRL_RUN = '{
        wpcir:     1'b1,
        if_flush:  1'b0,
        id_bubble: 1'b0,
        de_en:     1'b1,
        em_en:     1'b1,
        mw_bubble: 1'b0
    };

    // Instruction word loaded into IF/ID on a flush (sll $0,$0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Width of the memory-wait counter; holds any timeout up to 255.
    localparam int WAIT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug.
// Count updates one cycle after inc is sampled.
// No backpressure; increments are dropped once the counter reaches all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold at all-ones, clear on synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, ID redirect, data-memory wait.
// Enables and bubbles are combinational (zero latency); state, mem_err and counters register.
// A memory wait freezes PC..EX/MEM and bubbles MEM/WB until ready, drop of request, or timeout.
module pipe_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter bit          DELAY_SLOT  = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int          CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [4:0]       ern,
    input  logic             em2reg,
    input  logic             ewreg,
    input  logic             redirect,
    input  logic             mmem_req,
    input  logic             mem_ready,
    output logic             wpcir,
    output logic             if_flush,
    output logic             id_bubble,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              timed_out;
    logic              mem_stall;
    logic              load_use;
    logic              err_set;
    hz_ctrl_t          ctrl;

    // The wait has run its full budget: this cycle releases the pipeline regardless of memory.
    assign timed_out = (state == MEM_WAIT) && (wait_cnt == TIMEOUT);
    assign mem_stall = mmem_req && !mem_ready && !timed_out;

    // A load in EX feeding an ID source register cannot be forwarded in time.
    assign load_use = ewreg && em2reg && (ern != 5'd0) &&
                      ((use_rs && (rs == ern)) || (use_rt && (rt == ern)));

    // Priority: memory freeze over load-use bubble over redirect flush.
    always_comb begin
        ctrl = CTRL_RUN;
        if (mem_stall) begin
            ctrl.wpcir     = 1'b0;
            ctrl.de_en     = 1'b0;
            ctrl.em_en     = 1'b0;
            ctrl.mw_bubble = 1'b1;
        end else if (load_use) begin
            // ID operands are stale, so a redirect decided from them is ignored.
            ctrl.wpcir     = 1'b0;
            ctrl.id_bubble = 1'b1;
        end else if (redirect && (DELAY_SLOT == 1'b0)) begin
            ctrl.if_flush  = 1'b1;
        end
    end

    assign wpcir     = ctrl.wpcir;
    assign if_flush  = ctrl.if_flush;
    assign id_bubble = ctrl.id_bubble;
    assign de_en     = ctrl.de_en;
    assign em_en     = ctrl.em_en;
    assign mw_bubble = ctrl.mw_bubble;

    // Next state: stay frozen while the access stalls; any other outcome returns to RUN.
    always_comb begin
        state_nxt = RUN;
        wait_nxt  = '0;
        err_set   = 1'b0;
        if (mem_stall) begin
            state_nxt = MEM_WAIT;
            wait_nxt  = wait_cnt + WAIT_W'(1);
        end
        // Forced release with the access still outstanding: the access is abandoned.
        if (timed_out && mmem_req && !mem_ready) begin
            err_set = 1'b1;
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            mem_err  <= mem_err | err_set;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (!ctrl.wpcir),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (ctrl.if_flush),
        .count (flush_cnt)
    );

endmodule
